// File: rtl/fir_stream_mc_if.sv
// Stream-in / stream-out / coefficient-write bundle for fir_stream_mc.
// sat_flag is present only when FIR_SATURATE_EN is defined.
interface fir_stream_mc_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int N_TAPS = 32,
    parameter int NUM_CH = 1
) ();
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAP_W = $clog2(N_TAPS);

    logic              s_axis_data_tvalid;
    logic              s_axis_data_tready;
    logic [DATA_W-1:0] s_axis_data_tdata;
    logic              m_axis_data_tvalid;
    logic              m_axis_data_tready;
    logic [DATA_W-1:0] m_axis_data_tdata;
    logic [CH_W-1:0]   m_axis_data_tuser;
    logic              coef_wr_en;
    logic [TAP_W-1:0]  coef_wr_addr;
    logic [COEF_W-1:0] coef_wr_data;
`ifdef FIR_SATURATE_EN
    logic              sat_flag;
`endif

    modport slave (
        input  s_axis_data_tvalid, s_axis_data_tdata, m_axis_data_tready,
        input  coef_wr_en, coef_wr_addr, coef_wr_data,
        output s_axis_data_tready, m_axis_data_tvalid, m_axis_data_tdata,
        output m_axis_data_tuser
`ifdef FIR_SATURATE_EN
        , output sat_flag
`endif
    );

    modport master (
        output s_axis_data_tvalid, s_axis_data_tdata, m_axis_data_tready,
        output coef_wr_en, coef_wr_addr, coef_wr_data,
        input  s_axis_data_tready, m_axis_data_tvalid, m_axis_data_tdata,
        input  m_axis_data_tuser
`ifdef FIR_SATURATE_EN
        , input sat_flag
`endif
    );
endinterface

// File: rtl/fir_stream_mc.sv
// Time-multiplexed multi-channel FIR: one MAC per clock, round-robin channels, coef RAM writable in IDLE.
// Latency: tvalid rises N_TAPS edges after accept (first seen high on edge N_TAPS+1); one sample per N_TAPS+2 clocks.
// Backpressure: result held until m tready; s tready only in IDLE. FIR_SATURATE_EN: saturate output + sat_flag.
module fir_stream_mc #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int N_TAPS    = 32,
    parameter int NUM_CH    = 1,
    parameter int OUT_SHIFT = 15
) (
    input  logic           aclk,
    input  logic           aresetn,
    fir_stream_mc_if.slave bus
);
    localparam int TAP_W    = $clog2(N_TAPS);
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W    = DATA_W + COEF_W + TAP_W;
    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int DL_DEPTH = NUM_CH * N_TAPS;
    localparam int DL_AW    = $clog2(DL_DEPTH);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_MAC, ST_OUT} state_t;

    state_t                   state_q, state_d;
    logic [DL_AW-1:0]         clr_q, clr_d;
    logic [TAP_W-1:0]         tap_q, tap_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [TAP_W-1:0]         wp_q [NUM_CH];
    logic [TAP_W-1:0]         wp_d [NUM_CH];
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    logic signed [DATA_W-1:0] dl_q   [DL_DEPTH];
    logic signed [COEF_W-1:0] coef_q [N_TAPS];

    logic                     dl_we, coef_we;
    logic [DL_AW-1:0]         dl_wa;
    logic signed [DATA_W-1:0] dl_wd;
    logic [TAP_W-1:0]         coef_wa;
    logic signed [COEF_W-1:0] coef_wd;

    logic [TAP_W-1:0]         rd_tap;
    logic [DL_AW-1:0]         rd_addr, wr_addr;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sh;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic                     sat_q, sat_d;
    logic signed [ACC_W-1:0]  acc_nsh;
`endif

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        tap_d   = tap_q;
        ch_d    = ch_q;
        wp_d    = wp_q;
        acc_d   = acc_q;
        dl_we   = 1'b0;
        dl_wa   = clr_q;
        dl_wd   = '0;
        coef_we = 1'b0;
        coef_wa = clr_q[TAP_W-1:0];
        coef_wd = '0;
`ifdef FIR_SATURATE_EN
        sat_d   = 1'b0;
        acc_nsh = '0;
`endif
        // Newest sample sits one behind the (already advanced) write pointer.
        rd_tap  = wp_q[ch_q] - TAP_W'(1) - tap_q;
        rd_addr = DL_AW'(int'(ch_q) * N_TAPS + int'(rd_tap));
        wr_addr = DL_AW'(int'(ch_q) * N_TAPS + int'(wp_q[ch_q]));
        prod    = PROD_W'(coef_q[tap_q]) * PROD_W'(dl_q[rd_addr]);

        case (state_q)
            ST_CLEAR: begin
                dl_we   = 1'b1;
                coef_we = 1'b1;
                if (clr_q == DL_AW'(DL_DEPTH - 1)) begin
                    clr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    clr_d = clr_q + DL_AW'(1);
                end
            end
            ST_IDLE: begin
                if (bus.coef_wr_en) begin
                    coef_we = 1'b1;
                    coef_wa = bus.coef_wr_addr;
                    coef_wd = bus.coef_wr_data;
                end
                if (bus.s_axis_data_tvalid) begin
                    dl_we       = 1'b1;
                    dl_wa       = wr_addr;
                    dl_wd       = bus.s_axis_data_tdata;
                    wp_d[ch_q]  = wp_q[ch_q] + TAP_W'(1);
                    acc_d       = '0;
                    tap_d       = '0;
                    state_d     = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(N_TAPS - 1)) begin
                    state_d = ST_OUT;
`ifdef FIR_SATURATE_EN
                    acc_nsh = acc_d >>> OUT_SHIFT;
                    sat_d   = (acc_nsh > SAT_MAX) || (acc_nsh < SAT_MIN);
`endif
                end
            end
            ST_OUT: begin
                if (bus.m_axis_data_tready) begin
                    state_d = ST_IDLE;
                    ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
            tap_q   <= '0;
            ch_q    <= '0;
            wp_q    <= '{default: '0};
            acc_q   <= '0;
`ifdef FIR_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            tap_q   <= tap_d;
            ch_q    <= ch_d;
            wp_q    <= wp_d;
            acc_q   <= acc_d;
`ifdef FIR_SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Storage is zeroed by the CLEAR walk, not by reset.
    always_ff @(posedge aclk) begin
        if (dl_we)   dl_q[dl_wa]     <= dl_wd;
        if (coef_we) coef_q[coef_wa] <= coef_wd;
    end

    always_comb begin
        acc_sh = acc_q >>> OUT_SHIFT;
    end

    assign bus.s_axis_data_tready = (state_q == ST_IDLE);
    assign bus.m_axis_data_tvalid = (state_q == ST_OUT);
    assign bus.m_axis_data_tuser  = ch_q;

`ifdef FIR_SATURATE_EN
    assign bus.m_axis_data_tdata = (acc_sh > SAT_MAX) ? DATA_W'(SAT_MAX) :
                                   (acc_sh < SAT_MIN) ? DATA_W'(SAT_MIN) : DATA_W'(acc_sh);
    assign bus.sat_flag          = sat_q;
`else
    assign bus.m_axis_data_tdata = DATA_W'(acc_sh);
`endif
endmodule

// File: tb/tb_fir_stream_mc.sv
// Randomised and directed bench for fir_stream_mc (N_TAPS=4, NUM_CH=2, OUT_SHIFT=0)
// against a per-channel history-array FIR model.
`timescale 1ns/1ps
module tb_fir_stream_mc;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int N_TAPS    = 4;
    localparam int NUM_CH    = 2;
    localparam int OUT_SHIFT = 0;
    localparam int CH_W      = 1;
    localparam int CLR_CYC   = NUM_CH * N_TAPS;
    localparam longint MAXV  = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint MINV  = -(longint'(1) <<< (DATA_W - 1));

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    fir_stream_mc_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .N_TAPS(N_TAPS), .NUM_CH(NUM_CH)) bus ();

    fir_stream_mc #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .N_TAPS(N_TAPS), .NUM_CH(NUM_CH), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int m_coef [N_TAPS];
    int m_x    [NUM_CH][N_TAPS];
    int m_ch;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_TAPS; k++) m_coef[k] = 0;
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < N_TAPS; k++) m_x[c][k] = 0;
        m_ch = 0;
    endtask

    // y = sum c[k]*x[n-k] over this channel's history, shifted then narrowed.
    task automatic model_push(input logic [DATA_W-1:0] x, output logic [DATA_W-1:0] ed,
                              output logic [CH_W-1:0] eu, output bit es);
        longint sum;
        for (int k = N_TAPS - 1; k > 0; k--) m_x[m_ch][k] = m_x[m_ch][k-1];
        m_x[m_ch][0] = int'($signed(x));
        sum = 0;
        for (int k = 0; k < N_TAPS; k++) sum += longint'(m_coef[k]) * longint'(m_x[m_ch][k]);
        sum = sum >>> OUT_SHIFT;
        es  = (sum > MAXV) || (sum < MINV);
`ifdef FIR_SATURATE_EN
        if (sum > MAXV)      ed = DATA_W'(MAXV);
        else if (sum < MINV) ed = DATA_W'(MINV);
        else                 ed = DATA_W'(sum);
`else
        ed = sum[DATA_W-1:0];
`endif
        eu   = CH_W'(m_ch);
        m_ch = (m_ch + 1) % NUM_CH;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (bus.s_axis_data_tready !== 1'b1 && i < 100) begin tick(); i++; end
        n_cmp++;
        if (bus.s_axis_data_tready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_wait: s_tready=%b required 1", bus.s_axis_data_tready);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        model_reset();
        wait_idle();
    endtask

    task automatic write_coef(input int k, input int v);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = 2'(k);
        bus.coef_wr_data = 16'(v);
        m_coef[k] = v;
        tick();
        bus.coef_wr_en = 1'b0;
    endtask

    task automatic run_sample(input logic [DATA_W-1:0] x, input int hold, input bit chk_lat,
                              input bit cw_en, input int cw_addr, input int cw_data, input bit junk);
        int i;
        logic [DATA_W-1:0] ed;
        logic [CH_W-1:0]   eu;
        bit                es;
        wait_idle();
        bus.s_axis_data_tvalid = 1'b1;
        bus.s_axis_data_tdata  = x;
        if (cw_en) begin
            bus.coef_wr_en   = 1'b1;
            bus.coef_wr_addr = 2'(cw_addr);
            bus.coef_wr_data = 16'(cw_data);
            m_coef[cw_addr]  = cw_data;
        end
        model_push(x, ed, eu, es);
        if (hold > 0) bus.m_axis_data_tready = 1'b0;
        tick();
        bus.s_axis_data_tvalid = 1'b0;
        bus.coef_wr_en         = 1'b0;
        if (junk) begin
            bus.coef_wr_en   = 1'b1;
            bus.coef_wr_addr = 2'(0);
            bus.coef_wr_data = 16'(99);
        end
        i = 0;
        while (bus.m_axis_data_tvalid !== 1'b1 && i < N_TAPS + 20) begin tick(); i++; end
        bus.coef_wr_en = 1'b0;
        if (chk_lat) begin
            n_cmp++;
            if (i + 1 != N_TAPS + 1) begin
                n_err++;
                $display("FAIL latency: %0d edges, required %0d", i + 1, N_TAPS + 1);
            end
        end
        n_cmp++;
        if (bus.m_axis_data_tdata !== ed) begin
            n_err++;
            $display("FAIL data: in=%0d got %0d required %0d", $signed(x), $signed(bus.m_axis_data_tdata), $signed(ed));
        end
        n_cmp++;
        if (bus.m_axis_data_tuser !== eu) begin
            n_err++;
            $display("FAIL tuser: got %0d required %0d", bus.m_axis_data_tuser, eu);
        end
`ifdef FIR_SATURATE_EN
        n_cmp++;
        if (bus.sat_flag !== es) begin
            n_err++;
            $display("FAIL sat_flag: got %b required %b", bus.sat_flag, es);
        end
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            n_cmp++;
            if (bus.m_axis_data_tvalid !== 1'b1 || bus.m_axis_data_tdata !== ed || bus.s_axis_data_tready !== 1'b0) begin
                n_err++;
                $display("FAIL hold: cycle %0d tvalid=%b tdata=%0d s_tready=%b required 1/%0d/0",
                         h, bus.m_axis_data_tvalid, $signed(bus.m_axis_data_tdata), bus.s_axis_data_tready, $signed(ed));
            end
`ifdef FIR_SATURATE_EN
            n_cmp++;
            if (bus.sat_flag !== 1'b0) begin
                n_err++;
                $display("FAIL sat_pulse: got %b required 0 on hold cycle %0d", bus.sat_flag, h);
            end
`endif
        end
        bus.m_axis_data_tready = 1'b1;
        tick();
        n_cmp++;
        if (bus.m_axis_data_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL drop: tvalid=%b required 0 after handshake", bus.m_axis_data_tvalid);
        end
    endtask

    task automatic test_reset();
        int cnt;
        aresetn = 1'b0;
        tick();
        n_cmp++;
        if (bus.m_axis_data_tvalid !== 1'b0 || bus.s_axis_data_tready !== 1'b0 ||
            bus.m_axis_data_tdata !== '0 || bus.m_axis_data_tuser !== '0) begin
            n_err++;
            $display("FAIL reset_outs: tvalid=%b tready=%b tdata=%h tuser=%b required all 0",
                     bus.m_axis_data_tvalid, bus.s_axis_data_tready, bus.m_axis_data_tdata, bus.m_axis_data_tuser);
        end
        aresetn = 1'b1;
        model_reset();
        cnt = 0;
        while (bus.s_axis_data_tready !== 1'b1 && cnt < 50) begin cnt++; tick(); end
        n_cmp++;
        if (cnt != CLR_CYC) begin
            n_err++;
            $display("FAIL clear_len: tready low %0d cycles, required %0d", cnt, CLR_CYC);
        end
    endtask

    task automatic test_impulse();
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 3); write_coef(3, 4);
        run_sample(16'd1, 0, 1'b1, 1'b0, 0, 0, 1'b0);
        run_sample(16'd1, 0, 1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 2 * 5 - 2; i++) run_sample(16'd0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_sample(16'd7, 20, 1'b1, 1'b0, 0, 0, 1'b0);
        run_sample(16'hFFF0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_channels();
        do_reset();
        write_coef(0, 1);
        run_sample(16'd10, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_sample(16'd20, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_sample(16'd30, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_sample(16'd40, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        write_coef(0, 0); write_coef(1, 1);
        run_sample(16'd50, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        // Write and accept on the same edge: new tap 0 is used by this sample.
        run_sample(16'd60, 0, 1'b0, 1'b1, 0, 2, 1'b0);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < N_TAPS; k++) write_coef(k, 32767);
        for (int i = 0; i < 2 * N_TAPS; i++) run_sample(16'd32767, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_mac();
        int seen;
        wait_idle();
        bus.s_axis_data_tvalid = 1'b1;
        bus.s_axis_data_tdata  = 16'd1234;
        tick();
        bus.s_axis_data_tvalid = 1'b0;
        tick();
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (bus.m_axis_data_tvalid !== 1'b0 || bus.s_axis_data_tready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: tvalid=%b tready=%b required 0/0", bus.m_axis_data_tvalid, bus.s_axis_data_tready);
        end
        tick();
        aresetn = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < CLR_CYC + N_TAPS + 4; i++) begin
            if (bus.m_axis_data_tvalid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL ghost_beat: %0d tvalid cycles after mid-MAC reset, required 0", seen);
        end
        run_sample(16'd1, 0, 1'b1, 1'b0, 0, 0, 1'b0);
        run_sample(16'd1, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_sample(16'd0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_coef_during_mac();
        do_reset();
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 3); write_coef(3, 4);
        run_sample(16'd1, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) run_sample(16'd0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < N_TAPS; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 24; i++) begin
            logic [DATA_W-1:0] x;
            bit cw;
            x  = 16'($urandom_range(0, 65535));
            cw = ($urandom_range(0, 3) == 0);
            run_sample(x, int'($urandom_range(0, 2)), 1'b0, cw, int'($urandom_range(0, N_TAPS - 1)),
                       int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tdata  = '0;
        bus.m_axis_data_tready = 1'b1;
        bus.coef_wr_en         = 1'b0;
        bus.coef_wr_addr       = '0;
        bus.coef_wr_data       = '0;
        model_reset();
        test_reset();
        test_impulse();
        test_backpressure();
        test_channels();
        test_saturate();
        test_reset_mid_mac();
        test_coef_during_mac();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fir_stream_mc.md
Name: fir_stream_mc

Overview:
- Parametrised, multi-channel, time-multiplexed FIR filter core with AXI-Stream-style input and output handshakes. Successor to the fixed single-channel core.
- Adds generic width, tap count and channel count, a runtime-loadable coefficient RAM, and output backpressure.
- Sits between the audio sample source and the downstream sink; benches drive it with 16-bit audio samples.

Parameters:
DATA_W, 16, sample width (signed, two's complement) on input and output
COEF_W, 16, coefficient width (signed)
N_TAPS, 32, filter length; power of two, 4..256
NUM_CH, 1, interleaved channels, 1..8, each with an independent delay line
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output narrowing

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_data_tvalid  in  1  input sample valid
s_axis_data_tready  out  1  core can accept a sample
s_axis_data_tdata  in  DATA_W  input sample
m_axis_data_tvalid  out  1  output sample valid
m_axis_data_tready  in  1  sink accepts output
m_axis_data_tdata  out  DATA_W  filtered sample
m_axis_data_tuser  out  max(1,clog2(NUM_CH))  channel index of the output sample
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  clog2(N_TAPS)  tap index k
coef_wr_data  in  COEF_W  coefficient c[k]; shared by all channels

Behaviour:
- Reset (aresetn low, asynchronous):
  - All outputs go to 0; state = CLEAR; channel and tap counters = 0.
  - Internal ACC_W = DATA_W+COEF_W+clog2(N_TAPS).
- CLEAR state:
  - Walks every delay-line and coefficient address, writing 0 at one address per clock. Takes max(NUM_CH*N_TAPS, N_TAPS) cycles.
  - s_axis_data_tready is held 0; coef writes are ignored.
  - Exits to IDLE.
- IDLE state:
  - s_axis_data_tready = 1.
  - On tvalid&tready, the sample is written to the current channel's delay line at that channel's write pointer, and the pointer advances mod N_TAPS (wrap-around). Accumulator = 0. Go to MAC.
- MAC state:
  - tready = 0.
  - One multiply-accumulate per clock, k = 0..N_TAPS-1: acc += c[k]*x[n-k], with x indexed circularly per channel.
  - Exactly N_TAPS cycles, then go to OUT.
- OUT state:
  - Result = acc >>> OUT_SHIFT, narrowed to DATA_W by wrap (discard upper bits).
  - m_axis_data_tvalid is asserted with tdata and tuser held stable until m_axis_data_tready is sampled high.
  - On that handshake: tvalid drops, the channel counter advances (wraps NUM_CH-1 -> 0), go to IDLE.
- Latency and throughput:
  - First clock with tvalid=1 is N_TAPS+1 edges after the accepting edge.
  - With tready held high, throughput is one sample per N_TAPS+2 clocks.
- Channel assignment: input samples are assigned to channels round-robin, starting at channel 0 after reset.
- Coefficient writes:
  - Accepted only in IDLE, taking effect for the next sample.
  - In CLEAR, MAC or OUT they are silently dropped (no queuing).
  - Write and sample acceptance on the same IDLE edge: the coefficient write lands first, but the new coefficient is used by this sample's MAC.
- Reset mid-MAC or mid-OUT: the pending result is discarded (no output beat) and the CLEAR sequence reruns.
- tdata/tuser must not change while tvalid=1 and tready=0.

Optional Feature:
- Macro: FIR_SATURATE_EN.
- Defined: the shifted accumulator is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] instead of wrapped. An extra output port, sat_flag (1 bit), pulses high for one clock coincident with the first tvalid cycle of a saturated result; it resets to 0.
- Undefined: wrap narrowing is used and sat_flag does not exist.

Test Plan (N_TAPS=4, NUM_CH=1, OUT_SHIFT=0 unless stated):
1. Coefficients {1,2,3,4}, input 1,0,0,0,0 -> outputs 1,2,3,4,0; first tvalid exactly 5 edges after the first accept; tready low for the 4 CLEAR cycles after reset.
2. m_axis_data_tready held 0 for 20 cycles during OUT -> tvalid and tdata stable throughout; s_axis_data_tready stays 0; no sample is lost once tready is released.
3. NUM_CH=2, coefficients {1,0,0,0} then rewritten to {0,1,0,0} in IDLE; input 10,20,30,40 -> tuser 0,1,0,1 with data 10,20,30,40; afterwards each channel outputs its own previous sample.
4. Coefficients all 32767, input 32767 x4 -> with FIR_SATURATE_EN: output 32767 with sat_flag pulse; without: wrapped low 16 bits of 4294705156.
5. aresetn pulsed low mid-MAC -> no output beat; tvalid=0 immediately; CLEAR reruns; next impulse yields all-zero outputs until coefficients are reloaded.
6. coef_wr_en asserted during MAC with data 99 -> write ignored; the next impulse response is unchanged.
